axilite_mem_sp: RTL and testbench

- Parametrised AXI4-Lite slave memory; next-generation data-store endpoint for the AXI memory testbench.
- Configurable data width and depth; byte addressing; optional byte strobes.
- Independent read and write FSMs run concurrently.
- AW and W are accepted in either order; read latency is programmable; out-of-range accesses return SLVERR.

---
 rtl/axilite_mem_sp.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_axilite_mem_sp.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axilite_mem_sp.sv
// axilite_mem_sp
// AXI4-Lite slave memory: a DEPTH x DATA_W word store with byte addressing.
// Write and read channels are served by independent FSMs that run
// concurrently. AW and W may arrive in either order or together. Read data
// is returned a fixed RD_LAT cycles after the AR handshake. Accesses whose
// word index is not below DEPTH return SLVERR; writes to them are dropped.
//
// Optional feature macro: AXIL_MEM_WSTRB_EN
//   defined   : s_axi_wstrb port exists; only strobed bytes are written
//   undefined : no strobe port; every write replaces the full word
//
// Ports
//   s_axi_aclk      in   clock, rising edge
//   s_axi_areset    in   asynchronous active-high reset
//   s_axi_aw*       AW channel (valid/ready/addr)
//   s_axi_w*        W channel  (valid/ready/data[/strb])
//   s_axi_b*        B channel  (valid/ready/resp)
//   s_axi_ar*       AR channel (valid/ready/addr)
//   s_axi_r*        R channel  (valid/ready/data/resp)
//
// Write FSM
//   state     | meaning
//   W_COLLECT | accepting AW and/or W until both are held
//   W_RESP    | bvalid asserted, waiting for bready
//
// Read FSM
//   state  | meaning
//   R_IDLE | arready high, waiting for AR
//   R_WAIT | counting latency cycles before sampling memory
//   R_DATA | rvalid asserted, waiting for rready
module axilite_mem_sp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 2
) (
  input  logic                s_axi_aclk,
  input  logic                s_axi_areset,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
`ifdef AXIL_MEM_WSTRB_EN
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
`endif
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  output logic [1:0]          s_axi_bresp,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = 3;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_COLLECT, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // ---------------------------------------------------------------- write
  wr_state_t         r_wr_state;
  wr_state_t         w_wr_state_nxt;
  logic              r_aw_held;
  logic              r_w_held;
  logic [ADDR_W-1:0] r_awaddr;
  logic [DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_wstrb;
  logic              r_bvalid;
  logic [1:0]        r_bresp;

  logic              w_awready;
  logic              w_wready;
  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_wr_commit;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic [STRB_W-1:0] w_wr_strb;
  logic [STRB_W-1:0] w_in_strb;
  logic [ADDR_W-1:0] w_wr_word;
  logic              w_wr_in_range;
  logic [IDX_W-1:0]  w_wr_idx;
  logic              w_wr_we;

`ifdef AXIL_MEM_WSTRB_EN
  assign w_in_strb = s_axi_wstrb;
`else
  assign w_in_strb = '1;
`endif

  // A commit happens on the same edge as the second of the two handshakes,
  // so the address/data used are the live inputs when the handshake is now.
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_awready      = 1'b0;
    w_wready       = 1'b0;
    w_aw_hs        = 1'b0;
    w_w_hs         = 1'b0;
    w_wr_commit    = 1'b0;
    w_wr_addr      = r_awaddr;
    w_wr_data      = r_wdata;
    w_wr_strb      = r_wstrb;
    case (r_wr_state)
      W_COLLECT: begin
        w_awready = !r_aw_held && !s_axi_areset;
        w_wready  = !r_w_held && !s_axi_areset;
        w_aw_hs   = w_awready && s_axi_awvalid;
        w_w_hs    = w_wready && s_axi_wvalid;
        if (w_aw_hs) w_wr_addr = s_axi_awaddr;
        if (w_w_hs) begin
          w_wr_data = s_axi_wdata;
          w_wr_strb = w_in_strb;
        end
        if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) begin
          w_wr_commit    = 1'b1;
          w_wr_state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (r_bvalid && s_axi_bready) w_wr_state_nxt = W_COLLECT;
      end
      default: w_wr_state_nxt = W_COLLECT;
    endcase
  end

  // Full-width shift keeps the upper bits in the range check: no aliasing.
  assign w_wr_word     = w_wr_addr >> OFF_W;
  assign w_wr_in_range = w_wr_word < ADDR_W'(DEPTH);
  assign w_wr_idx      = w_wr_word[IDX_W-1:0];
  assign w_wr_we       = w_wr_commit && w_wr_in_range;

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) r_wr_state <= W_COLLECT;
    else              r_wr_state <= w_wr_state_nxt;
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      if (w_aw_hs) begin
        r_awaddr  <= s_axi_awaddr;
        r_aw_held <= 1'b1;
      end
      if (w_w_hs) begin
        r_wdata  <= s_axi_wdata;
        r_wstrb  <= w_in_strb;
        r_w_held <= 1'b1;
      end
      if (w_wr_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if ((r_wr_state == W_RESP) && r_bvalid && s_axi_bready) begin
        r_bvalid <= 1'b0;
        r_bresp  <= RESP_OKAY;
      end
    end
  end

  // Memory has no reset: contents survive s_axi_areset.
  always_ff @(posedge s_axi_aclk) begin
    if (w_wr_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_wr_strb[b]) r_mem[w_wr_idx][b*8 +: 8] <= w_wr_data[b*8 +: 8];
      end
    end
  end

  assign s_axi_awready = w_awready;
  assign s_axi_wready  = w_wready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;

  // ----------------------------------------------------------------- read
  rd_state_t         r_rd_state;
  rd_state_t         w_rd_state_nxt;
  logic [ADDR_W-1:0] r_araddr;
  logic [CNT_W-1:0]  r_rd_cnt;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_rresp;

  logic              w_arready;
  logic              w_ar_hs;
  logic              w_rd_load;
  logic              w_rd_err;
  logic              w_rd_done;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] w_rd_word;
  logic              w_rd_in_range;
  logic [IDX_W-1:0]  w_rd_idx;

  // In R_IDLE the sample (RD_LAT == 1) or range check uses the live address.
  assign w_rd_addr     = (r_rd_state == R_IDLE) ? s_axi_araddr : r_araddr;
  assign w_rd_word     = w_rd_addr >> OFF_W;
  assign w_rd_in_range = w_rd_word < ADDR_W'(DEPTH);
  assign w_rd_idx      = w_rd_word[IDX_W-1:0];

  // The count tracks cycles since the AR handshake; memory is sampled on the
  // edge where it reaches RD_LAT so rvalid rises RD_LAT cycles after AR.
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_arready      = 1'b0;
    w_ar_hs        = 1'b0;
    w_rd_load      = 1'b0;
    w_rd_err       = 1'b0;
    w_rd_done      = 1'b0;
    w_cnt_nxt      = r_rd_cnt;
    case (r_rd_state)
      R_IDLE: begin
        w_arready = !s_axi_areset;
        w_ar_hs   = w_arready && s_axi_arvalid;
        if (w_ar_hs) begin
          if (!w_rd_in_range) begin
            w_rd_err       = 1'b1;
            w_rd_state_nxt = R_DATA;
          end else if (RD_LAT == 1) begin
            w_rd_load      = 1'b1;
            w_rd_state_nxt = R_DATA;
          end else begin
            w_cnt_nxt      = CNT_W'(1);
            w_rd_state_nxt = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        w_cnt_nxt = r_rd_cnt + CNT_W'(1);
        if (w_cnt_nxt == CNT_W'(RD_LAT)) begin
          w_rd_load      = 1'b1;
          w_rd_state_nxt = R_DATA;
        end
      end
      R_DATA: begin
        if (r_rvalid && s_axi_rready) begin
          w_rd_done      = 1'b1;
          w_rd_state_nxt = R_IDLE;
        end
      end
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) r_rd_state <= R_IDLE;
    else              r_rd_state <= w_rd_state_nxt;
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_araddr <= '0;
      r_rd_cnt <= '0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else begin
      if (w_ar_hs) r_araddr <= s_axi_araddr;
      r_rd_cnt <= (w_rd_load || w_rd_err) ? '0 : w_cnt_nxt;
      if (w_rd_load) begin
        r_rvalid <= 1'b1;
        r_rdata  <= r_mem[w_rd_idx];
        r_rresp  <= RESP_OKAY;
      end else if (w_rd_err) begin
        r_rvalid <= 1'b1;
        r_rdata  <= '0;
        r_rresp  <= RESP_SLVERR;
      end else if (w_rd_done) begin
        r_rvalid <= 1'b0;
        r_rdata  <= '0;
        r_rresp  <= RESP_OKAY;
      end
    end
  end

  assign s_axi_arready = w_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;

endmodule

// File: tb/tb_axilite_mem_sp.sv
module tb_axilite_mem_sp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 256;
  localparam int RD_LAT = 2;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_axi_awvalid = 1'b0;
  logic              s_axi_awready;
  logic [ADDR_W-1:0] s_axi_awaddr = '0;
  logic              s_axi_wvalid = 1'b0;
  logic              s_axi_wready;
  logic [DATA_W-1:0] s_axi_wdata = '0;
  logic [3:0]        s_axi_wstrb = 4'hF;
  logic              s_axi_bvalid;
  logic              s_axi_bready = 1'b1;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_arvalid = 1'b0;
  logic              s_axi_arready;
  logic [ADDR_W-1:0] s_axi_araddr = '0;
  logic              s_axi_rvalid;
  logic              s_axi_rready = 1'b1;
  logic [DATA_W-1:0] s_axi_rdata;
  logic [1:0]        s_axi_rresp;

  axilite_mem_sp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .s_axi_aclk   (clk),
    .s_axi_areset (rst),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_awaddr (s_axi_awaddr),
    .s_axi_wvalid (s_axi_wvalid),
    .s_axi_wready (s_axi_wready),
    .s_axi_wdata  (s_axi_wdata),
`ifdef AXIL_MEM_WSTRB_EN
    .s_axi_wstrb  (s_axi_wstrb),
`endif
    .s_axi_bvalid (s_axi_bvalid),
    .s_axi_bready (s_axi_bready),
    .s_axi_bresp  (s_axi_bresp),
    .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_araddr (s_axi_araddr),
    .s_axi_rvalid (s_axi_rvalid),
    .s_axi_rready (s_axi_rready),
    .s_axi_rdata  (s_axi_rdata),
    .s_axi_rresp  (s_axi_rresp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {logic [1:0] resp; int exp_edge;} b_exp_t;
  typedef struct {logic [31:0] data; logic [1:0] resp; int exp_edge;} r_exp_t;
  b_exp_t b_q[$];
  r_exp_t r_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ------------------------------------------------------------ monitor
  b_exp_t      be;
  r_exp_t      re;
  int          b_rise = -1;
  int          r_rise = -1;
  int          r_seen = 0;
  logic        b_prev = 1'b0, r_prev = 1'b0;
  logic        b_stall_d = 1'b0, r_stall_d = 1'b0;
  logic [1:0]  b_hold = '0, rr_hold = '0;
  logic [31:0] rd_hold = '0;

  always @(negedge clk) begin
    if (rst) begin
      b_prev = 1'b0; r_prev = 1'b0; b_stall_d = 1'b0; r_stall_d = 1'b0;
    end else begin
      if (s_axi_bvalid && !b_prev) b_rise = cyc;
      if (b_stall_d) begin
        check("b_hold_valid", 64'(s_axi_bvalid), 64'd1);
        check("b_hold_resp", 64'(s_axi_bresp), 64'(b_hold));
      end
      if (s_axi_bvalid && s_axi_bready) begin
        if (b_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL b_unexpected: got bvalid resp %0h with no write outstanding", s_axi_bresp);
        end else begin
          be = b_q.pop_front();
          check("bresp", 64'(s_axi_bresp), 64'(be.resp));
          check("b_latency_edge", 64'(b_rise), 64'(be.exp_edge));
        end
      end
      b_stall_d = s_axi_bvalid && !s_axi_bready;
      b_hold    = s_axi_bresp;
      b_prev    = s_axi_bvalid;

      if (s_axi_rvalid && !r_prev) begin
        r_rise = cyc;
        r_seen++;
      end
      if (r_stall_d) begin
        check("r_hold_valid", 64'(s_axi_rvalid), 64'd1);
        check("r_hold_data", 64'(s_axi_rdata), 64'(rd_hold));
        check("r_hold_resp", 64'(s_axi_rresp), 64'(rr_hold));
      end
      if (s_axi_rvalid && s_axi_rready) begin
        if (r_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL r_unexpected: got rvalid data %0h with no read outstanding", s_axi_rdata);
        end else begin
          re = r_q.pop_front();
          check("rdata", 64'(s_axi_rdata), 64'(re.data));
          check("rresp", 64'(s_axi_rresp), 64'(re.resp));
          check("r_latency_edge", 64'(r_rise), 64'(re.exp_edge));
        end
      end
      r_stall_d = s_axi_rvalid && !s_axi_rready;
      rd_hold   = s_axi_rdata;
      rr_hold   = s_axi_rresp;
      r_prev    = s_axi_rvalid;
    end
  end

  // ----------------------------------------------------------- stimulus
  // All tasks start and end at posedge+1; the edge index of a handshake is
  // cyc+1 when ready is seen at the preceding negedge.
  task automatic send_aw(input logic [31:0] a, output int e);
    s_axi_awvalid = 1'b1; s_axi_awaddr = a; e = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_axi_awready) begin e = cyc + 1; break; end
    end
    if (e < 0) begin checks++; failures++; $display("FAIL aw_timeout: no awready for addr %0h", a); end
    @(posedge clk); #1; s_axi_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, output int e);
    s_axi_wvalid = 1'b1; s_axi_wdata = d; s_axi_wstrb = s; e = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_axi_wready) begin e = cyc + 1; break; end
    end
    if (e < 0) begin checks++; failures++; $display("FAIL w_timeout: no wready for data %0h", d); end
    @(posedge clk); #1; s_axi_wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a, output int e);
    s_axi_arvalid = 1'b1; s_axi_araddr = a; e = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_axi_arready) begin e = cyc + 1; break; end
    end
    if (e < 0) begin checks++; failures++; $display("FAIL ar_timeout: no arready for addr %0h", a); end
    @(posedge clk); #1; s_axi_arvalid = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int aw_dly, input int w_dly, input logic [1:0] resp);
    int ea, ew;
    fork
      begin repeat (aw_dly) begin @(posedge clk); #1; end send_aw(a, ea); end
      begin repeat (w_dly) begin @(posedge clk); #1; end send_w(d, s, ew); end
    join
    b_q.push_back('{resp, (ea > ew) ? ea : ew});
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp, input int lat);
    int e;
    send_ar(a, e);
    r_q.push_back('{d, resp, e + lat - 1});
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (b_q.size() == 0 && r_q.size() == 0 && !s_axi_bvalid && !s_axi_rvalid) break;
      @(posedge clk); #1;
    end
    check("drain_b_q", 64'(b_q.size()), 64'd0);
    check("drain_r_q", 64'(r_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  function automatic logic [40:0] all_outs();
    return {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid,
            s_axi_bresp, s_axi_rresp, s_axi_rdata};
  endfunction

  initial begin
    int e, seen0;
    @(posedge clk); #1;
    check("reset_outputs", 64'(all_outs()), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    wr(32'h0,  32'hAABBCCDD, 4'hF, 0, 0, OKAY);
    wr(32'h24, 32'h55667788, 4'hF, 0, 0, OKAY);
    // W first, AW three cycles later
    wr(32'h10, 32'hDEADBEEF, 4'hF, 6, 3, OKAY);
    rd(32'h10, 32'hDEADBEEF, OKAY, RD_LAT);

    // boundaries: last word, first out-of-range word, high address bit
    wr(32'h3FC, 32'h0BADF00D, 4'hF, 0, 0, OKAY);
    wr(32'h400, 32'hFFFFFFFF, 4'hF, 0, 0, SLVERR);
    rd(32'h400, 32'h0, SLVERR, 1);
    rd(32'h0,   32'hAABBCCDD, OKAY, RD_LAT);
    rd(32'h3FC, 32'h0BADF00D, OKAY, RD_LAT);
    rd(32'h13,  32'hDEADBEEF, OKAY, RD_LAT);
    rd(32'h8000_0010, 32'h0, SLVERR, 1);
    drain();

`ifdef AXIL_MEM_WSTRB_EN
    wr(32'h0, 32'h11223344, 4'b0101, 0, 0, OKAY);
    rd(32'h0, 32'hAA22CC44, OKAY, RD_LAT);
    wr(32'h0, 32'hFFFFFFFF, 4'b0000, 0, 0, OKAY);
    rd(32'h0, 32'hAA22CC44, OKAY, RD_LAT);
    drain();
`endif

    // backpressure on both response channels
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    fork
      wr(32'h30, 32'hCAFEF00D, 4'hF, 0, 0, OKAY);
      rd(32'h10, 32'hDEADBEEF, OKAY, RD_LAT);
    join
    for (int i = 0; i < 20; i++) begin
      if (s_axi_bvalid && s_axi_rvalid) break;
      @(posedge clk); #1;
    end
    check("bp_both_valid", 64'({s_axi_bvalid, s_axi_rvalid}), 64'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_readies_low", 64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'd0);
    end
    @(posedge clk); #1;
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    drain();
    repeat (4) @(posedge clk);
    #1;
    rd(32'h30, 32'hCAFEF00D, OKAY, RD_LAT);
    drain();

    // write to 0x24 commits on the same edge the read samples it: old data
    fork
      rd(32'h24, 32'h55667788, OKAY, RD_LAT);
      begin @(posedge clk); #1; wr(32'h24, 32'h99AABBCC, 4'hF, 0, 0, OKAY); end
    join
    drain();
    rd(32'h24, 32'h99AABBCC, OKAY, RD_LAT);
    drain();

    // independent paths issued in the same cycle
    fork
      wr(32'h20, 32'h00001234, 4'hF, 0, 0, OKAY);
      rd(32'h24, 32'h99AABBCC, OKAY, RD_LAT);
    join
    rd(32'h20, 32'h00001234, OKAY, RD_LAT);
    drain();

    // reset while the read is in R_WAIT
    send_ar(32'h10, e);
    seen0 = r_seen;
    rst = 1'b1;
    #1;
    check("midreset_outputs", 64'(all_outs()), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("no_rvalid_after_reset", 64'(r_seen), 64'(seen0));
    rd(32'h10, 32'hDEADBEEF, OKAY, RD_LAT);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
